// File: rtl/uart_text_cmd_pkg.sv
// Shared constants, state encoding and small helpers for the UART text command decoder.
// Screen geometry matches a 1024x768 display with 8x16 glyphs.
// Imported by the decoder top and its cell sweep counter.
package uart_text_cmd_pkg;

  localparam int N_COL  = 128;
  localparam int N_ROW  = 48;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;
  localparam int CHAR_W = 7;
  localparam int TO_W   = 17;

  localparam logic [7:0]        CMD_CLEAR  = 8'h80;
  localparam logic [CHAR_W-1:0] CHAR_SPACE = 7'h20;
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(N_COL - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(N_ROW - 1);

  typedef enum logic [2:0] {
    S_COL  = 3'd0,
    S_ROW  = 3'd1,
    S_CHAR = 3'd2,
    S_EOL  = 3'd3,
    S_CLR  = 3'd4
  } state_t;

  // Out-of-range columns fold back by one screen width; the subtract has no carry out.
  function automatic logic [COL_W-1:0] fold_col(input logic [COL_W-1:0] c);
    if ({1'b0, c} >= (COL_W + 1)'(N_COL)) return c - COL_W'(N_COL);
    else return c;
  endfunction

  // A row index past the last text row cannot be written.
  function automatic logic row_bad(input logic [ROW_W-1:0] r);
    return ({1'b0, r} >= (ROW_W + 1)'(N_ROW));
  endfunction

endpackage

// File: rtl/uart_text_cmd_cell_sweep.sv
// Column/row raster counter: visits every cell once, column fastest, after a start pulse.
// Position is valid the cycle after i_start and advances one cell per cycle while active.
// Position holds at the last cell after the sweep so callers can keep showing it.
module uart_text_cmd_cell_sweep
  import uart_text_cmd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_start,
  output logic             o_active,
  output logic             o_done,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row
);

  logic             r_active;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_last;

  assign w_last   = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign o_active = r_active;
  assign o_done   = r_active & w_last;
  assign o_col    = r_col;
  assign o_row    = r_row;

  // Raster walk: restart at (0,0) on start, stop after the bottom-right cell.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_col    <= '0;
      r_row    <= '0;
    end else if (r_active) begin
      if (w_last) begin
        r_active <= 1'b0;
      end else if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_text_cmd.sv
// Decodes UART bytes (col,row,char,terminator) and clear commands into screen-buffer writes.
// Character write appears one cycle after the char byte is taken; clear writes one cell per cycle.
// No backpressure: bytes arriving during a clear are dropped and flagged in the sticky error.
module uart_text_cmd
  import uart_text_cmd_pkg::*;
#(
  parameter int TIMEOUT = 65000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [7:0]        data_i,
  output logic              wr_en_o,
  output logic [COL_W-1:0]  col_w_o,
  output logic [ROW_W-1:0]  row_w_o,
  output logic [CHAR_W-1:0] din_o,
  output logic              busy_o,
  output logic              err_o
);

  logic              r_wr_d;
  logic              w_accept;
  state_t            r_state;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_timeout;
  logic [COL_W-1:0]  r_fcol;
  logic [ROW_W-1:0]  r_frow;
  logic              r_bad_row;
  logic              r_wr_en;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [CHAR_W-1:0] r_din;
  logic              r_src_sweep;
  logic              r_err;
  logic              w_clr_start;
  logic              w_sw_active;
  logic              w_sw_done;
  logic [COL_W-1:0]  w_sw_col;
  logic [ROW_W-1:0]  w_sw_row;

  assign w_accept    = wr_i & ~r_wr_d;
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT));
  assign w_clr_start = (r_state == S_COL) && w_accept && (data_i == CMD_CLEAR);

  uart_text_cmd_cell_sweep u_sweep (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_start  (w_clr_start),
    .o_active (w_sw_active),
    .o_done   (w_sw_done),
    .o_col    (w_sw_col),
    .o_row    (w_sw_row)
  );

  // The write port shows whichever source wrote last, so values hold between writes.
  assign wr_en_o = r_wr_en | w_sw_active;
  assign col_w_o = r_src_sweep ? w_sw_col : r_col;
  assign row_w_o = r_src_sweep ? w_sw_row : r_row;
  assign din_o   = r_src_sweep ? CHAR_SPACE : r_din;
  assign busy_o  = w_sw_active;
  assign err_o   = r_err;

  // Edge detector; resets high so a wr_i already high at reset release is not a byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_wr_d <= 1'b1;
    else       r_wr_d <= wr_i;
  end

  // Mid-frame idle counter; cleared by any byte and parked at zero outside a frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == S_COL || r_state == S_CLR || w_accept || w_timeout)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Frame decoder: one state per accepted byte, a timeout drops a partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_COL;
      r_fcol      <= '0;
      r_frow      <= '0;
      r_bad_row   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_din       <= '0;
      r_src_sweep <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_COL: begin
          if (w_accept) begin
            if (!data_i[7]) begin
              r_fcol  <= fold_col(data_i[COL_W-1:0]);
              r_state <= S_ROW;
            end else if (data_i == CMD_CLEAR) begin
              r_src_sweep <= 1'b1;
              r_state     <= S_CLR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ROW: begin
          if (w_accept) begin
            r_frow    <= data_i[ROW_W-1:0];
            r_bad_row <= row_bad(data_i[ROW_W-1:0]);
            if (row_bad(data_i[ROW_W-1:0])) r_err <= 1'b1;
            r_state <= S_CHAR;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_COL;
          end
        end
        S_CHAR: begin
          if (w_accept) begin
            if (!r_bad_row) begin
              r_wr_en     <= 1'b1;
              r_col       <= r_fcol;
              r_row       <= r_frow;
              r_din       <= data_i[CHAR_W-1:0];
              r_src_sweep <= 1'b0;
            end
            r_state <= S_EOL;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_COL;
          end
        end
        S_EOL: begin
          if (w_accept) begin
            r_state <= S_COL;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_COL;
          end
        end
        S_CLR: begin
          if (w_accept) r_err <= 1'b1;
          if (w_sw_done) r_state <= S_COL;
        end
        default: r_state <= S_COL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_text_cmd.sv
// Self-checking bench for uart_text_cmd: directed scenarios plus randomized frames.
// Expected writes come from a frame-level model (col, row range, 7-bit char).
// A negedge monitor logs every write with its cycle stamp for the tasks to check.
module tb_uart_text_cmd;
  import uart_text_cmd_pkg::*;

  localparam int TO = 300;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              wr_i;
  logic [7:0]        data_i;
  logic              wr_en_o;
  logic [COL_W-1:0]  col_w_o;
  logic [ROW_W-1:0]  row_w_o;
  logic [CHAR_W-1:0] din_o;
  logic              busy_o;
  logic              err_o;

  uart_text_cmd #(.TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .wr_i    (wr_i),
    .data_i  (data_i),
    .wr_en_o (wr_en_o),
    .col_w_o (col_w_o),
    .row_w_o (row_w_o),
    .din_o   (din_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int col;
    int row;
    int din;
  } wr_t;

  int  cyc = 0;
  wr_t wq[$];
  wr_t mon_e;
  int  busy_cnt = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en_o) begin
      mon_e.cyc = cyc;
      mon_e.col = int'(col_w_o);
      mon_e.row = int'(row_w_o);
      mon_e.din = int'(din_o);
      wq.push_back(mon_e);
    end
    if (busy_o) busy_cnt = busy_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One byte: wr_i high for one cycle then low for gap cycles; t is the send cycle.
  task automatic send_byte(input logic [7:0] b, input int gap, output int t);
    t = cyc;
    data_i = b;
    wr_i = 1'b1;
    @(negedge clk);
    wr_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] r, input logic [7:0] ch,
                            input int gap, output int t_ch);
    int t;
    send_byte(c, gap, t);
    send_byte(r, gap, t);
    send_byte(ch, gap, t_ch);
    send_byte(8'h0A, gap, t);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    wr_i = 1'b0;
    tick(2);
    rst_i = 1'b0;
    tick(1);
    wq.delete();
    busy_cnt = 0;
  endtask

  task automatic test_reset();
    int t;
    rst_i = 1'b1;
    wr_i = 1'b1;
    data_i = 8'h05;
    tick(3);
    n_chk++; if (wr_en_o !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", wr_en_o); else n_pass++;
    n_chk++; if (col_w_o !== 7'd0) $display("FAIL reset_col: got %0d want 0", col_w_o); else n_pass++;
    n_chk++; if (row_w_o !== 6'd0) $display("FAIL reset_row: got %0d want 0", row_w_o); else n_pass++;
    n_chk++; if (din_o !== 7'd0) $display("FAIL reset_din: got %0h want 0", din_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL reset_err: got %0b want 0", err_o); else n_pass++;
    // wr_i still high at release must not be taken as a byte
    rst_i = 1'b0;
    tick(3);
    wr_i = 1'b0;
    tick(1);
    wq.delete();
    send_frame(8'h09, 8'h04, 8'h41, 2, t);
    tick(3);
    n_chk++;
    if (wq.size() != 1 || wq[0].col != 9 || wq[0].row != 4 || wq[0].din != 'h41)
      $display("FAIL reset_no_false_edge: got %0d writes first (%0d,%0d,%0h) want 1 write (9,4,41)",
               wq.size(), wq.size() ? wq[0].col : -1, wq.size() ? wq[0].row : -1,
               wq.size() ? wq[0].din : -1);
    else n_pass++;
  endtask

  task automatic test_basic();
    int t;
    do_reset();
    send_frame(8'h05, 8'h03, 8'h41, 2, t);
    tick(3);
    n_chk++; if (wq.size() != 1) $display("FAIL basic_count: got %0d want 1", wq.size()); else n_pass++;
    if (wq.size() >= 1) begin
      n_chk++; if (wq[0].col != 5) $display("FAIL basic_col: got %0d want 5", wq[0].col); else n_pass++;
      n_chk++; if (wq[0].row != 3) $display("FAIL basic_row: got %0d want 3", wq[0].row); else n_pass++;
      n_chk++; if (wq[0].din != 'h41) $display("FAIL basic_din: got %0h want 41", wq[0].din); else n_pass++;
      n_chk++; if (wq[0].cyc != t + 1) $display("FAIL basic_latency: got cycle %0d want %0d", wq[0].cyc, t + 1); else n_pass++;
    end
    n_chk++; if (err_o !== 1'b0) $display("FAIL basic_err: got %0b want 0", err_o); else n_pass++;
  endtask

  task automatic test_edges();
    int t;
    do_reset();
    send_frame(8'h7F, 8'h2F, 8'h5A, 1, t);
    tick(3);
    n_chk++;
    if (wq.size() != 1 || wq[0].col != 127 || wq[0].row != 47 || wq[0].din != 'h5A)
      $display("FAIL edge_corner: got %0d writes want 1 write at (127,47,5a)", wq.size());
    else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL edge_corner_err: got %0b want 0", err_o); else n_pass++;
    send_frame(8'h10, 8'h30, 8'h41, 1, t);
    tick(3);
    n_chk++; if (wq.size() != 1) $display("FAIL edge_badrow_nowrite: got %0d writes want 1", wq.size()); else n_pass++;
    n_chk++; if (err_o !== 1'b1) $display("FAIL edge_badrow_err: got %0b want 1", err_o); else n_pass++;
    // an unknown command byte is ignored but flagged
    do_reset();
    send_byte(8'h85, 2, t);
    n_chk++; if (err_o !== 1'b1) $display("FAIL badcmd_err: got %0b want 1", err_o); else n_pass++;
    send_frame(8'h03, 8'h04, 8'h42, 1, t);
    tick(3);
    n_chk++;
    if (wq.size() != 1 || wq[0].col != 3 || wq[0].row != 4 || wq[0].din != 'h42)
      $display("FAIL badcmd_resync: got %0d writes want 1 write at (3,4,42)", wq.size());
    else n_pass++;
  endtask

  task automatic test_random_frames();
    wr_t exp_q[$];
    wr_t e;
    int  bad;
    int  nbad;
    int  c;
    int  rv;
    int  ch;
    int  t;
    logic [7:0] rb;
    logic [7:0] cb;
    do_reset();
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      c  = $urandom_range(0, 127);
      rv = ($urandom_range(0, 3) == 0) ? $urandom_range(48, 63) : $urandom_range(0, 47);
      ch = $urandom_range(0, 255);
      rb = {2'($urandom_range(0, 3)), 6'(rv)};
      cb = 8'(c);
      send_byte(cb, $urandom_range(1, 4), t);
      send_byte(rb, $urandom_range(1, 4), t);
      send_byte(8'(ch), $urandom_range(1, 4), t);
      send_byte(8'($urandom_range(0, 255)), $urandom_range(1, 4), t);
      if (rv < N_ROW) begin
        e.cyc = t;
        e.col = c % N_COL;
        e.row = rv;
        e.din = ch % 128;
        exp_q.push_back(e);
      end else begin
        bad = 1;
      end
    end
    tick(3);
    n_chk++;
    if (wq.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", wq.size(), exp_q.size());
    else n_pass++;
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      if (wq[i].col != exp_q[i].col || wq[i].row != exp_q[i].row || wq[i].din != exp_q[i].din) nbad++;
    n_chk++; if (nbad != 0) $display("FAIL rand_content: got %0d mismatching writes want 0", nbad); else n_pass++;
    n_chk++; if (err_o !== 1'(bad)) $display("FAIL rand_err: got %0b want %0d", err_o, bad); else n_pass++;
  endtask

  task automatic test_clear(input bit mid_byte);
    int t;
    int tt;
    int nbad;
    int first;
    bit done;
    do_reset();
    send_byte(CMD_CLEAR, 1, t);
    if (mid_byte) begin
      tick(1000);
      send_byte(8'h33, 1, tt);
    end
    done = 1'b0;
    for (int i = 0; i < 7000 && !done; i++) begin
      if (!busy_o) done = 1'b1;
      else @(negedge clk);
    end
    n_chk++; if (!done) $display("FAIL clear_timeout: busy_o still %0b after 7000 cycles want 0", busy_o); else n_pass++;
    tick(2);
    n_chk++; if (wq.size() != N_COL * N_ROW) $display("FAIL clear_pulses: got %0d want %0d", wq.size(), N_COL * N_ROW); else n_pass++;
    n_chk++; if (busy_cnt != N_COL * N_ROW) $display("FAIL clear_busy_cycles: got %0d want %0d", busy_cnt, N_COL * N_ROW); else n_pass++;
    if (wq.size() > 0) begin
      first = wq[0].cyc;
      n_chk++; if (first != t + 1) $display("FAIL clear_start: got cycle %0d want %0d", first, t + 1); else n_pass++;
      nbad = 0;
      for (int i = 0; i < wq.size(); i++)
        if (wq[i].col != i % N_COL || wq[i].row != i / N_COL || wq[i].din != 'h20 || wq[i].cyc != first + i)
          nbad++;
      n_chk++; if (nbad != 0) $display("FAIL clear_order: got %0d bad cells want 0", nbad); else n_pass++;
    end
    n_chk++; if (err_o !== 1'(mid_byte)) $display("FAIL clear_err: got %0b want %0b", err_o, mid_byte); else n_pass++;
    n_chk++;
    if (col_w_o !== 7'd127 || row_w_o !== 6'd47)
      $display("FAIL clear_hold: got (%0d,%0d) want (127,47)", col_w_o, row_w_o);
    else n_pass++;
    wq.delete();
    send_frame(8'h02, 8'h03, 8'h44, 1, t);
    tick(3);
    n_chk++;
    if (wq.size() != 1 || wq[0].col != 2 || wq[0].row != 3 || wq[0].din != 'h44)
      $display("FAIL clear_after_frame: got %0d writes want 1 write at (2,3,44)", wq.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int t;
    do_reset();
    send_byte(8'h05, TO - 20, t);
    send_byte(8'h03, TO - 20, t);
    send_byte(8'h41, TO - 20, t);
    send_byte(8'h0A, 2, t);
    n_chk++;
    if (wq.size() != 1 || wq[0].col != 5 || wq[0].row != 3)
      $display("FAIL slow_frame: got %0d writes want 1 write at (5,3)", wq.size());
    else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL slow_frame_err: got %0b want 0", err_o); else n_pass++;
    do_reset();
    send_byte(8'h05, 2, t);
    send_byte(8'h03, TO + 10, t);
    n_chk++; if (err_o !== 1'b1) $display("FAIL timeout_err: got %0b want 1", err_o); else n_pass++;
    n_chk++; if (wq.size() != 0) $display("FAIL timeout_nowrite: got %0d writes want 0", wq.size()); else n_pass++;
    send_frame(8'h01, 8'h01, 8'h42, 2, t);
    tick(3);
    n_chk++;
    if (wq.size() != 1 || wq[0].col != 1 || wq[0].row != 1 || wq[0].din != 'h42)
      $display("FAIL timeout_resync: got %0d writes want 1 write at (1,1,42)", wq.size());
    else n_pass++;
  endtask

  task automatic test_level_hold();
    int t;
    do_reset();
    data_i = 8'h07;
    wr_i = 1'b1;
    tick(10);
    wr_i = 1'b0;
    tick(1);
    send_byte(8'h02, 1, t);
    send_byte(8'h43, 1, t);
    send_byte(8'h0A, 1, t);
    tick(3);
    n_chk++;
    if (wq.size() != 1 || wq[0].col != 7 || wq[0].row != 2 || wq[0].din != 'h43)
      $display("FAIL level_hold: got %0d writes want 1 write at (7,2,43)", wq.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int t;
    do_reset();
    send_byte(CMD_CLEAR, 100, t);
    n_chk++; if (busy_o !== 1'b1) $display("FAIL midclr_busy_before: got %0b want 1", busy_o); else n_pass++;
    rst_i = 1'b1;
    tick(1);
    n_chk++; if (busy_o !== 1'b0) $display("FAIL midclr_busy_after: got %0b want 0", busy_o); else n_pass++;
    n_chk++; if (wr_en_o !== 1'b0) $display("FAIL midclr_wr_en: got %0b want 0", wr_en_o); else n_pass++;
    rst_i = 1'b0;
    wq.delete();
    tick(50);
    n_chk++; if (wq.size() != 0) $display("FAIL midclr_no_writes: got %0d want 0", wq.size()); else n_pass++;
    send_frame(8'h06, 8'h07, 8'h45, 1, t);
    tick(3);
    n_chk++;
    if (wq.size() != 1 || wq[0].col != 6 || wq[0].row != 7 || wq[0].din != 'h45)
      $display("FAIL midclr_frame: got %0d writes want 1 write at (6,7,45)", wq.size());
    else n_pass++;
  endtask

  initial begin
    rst_i = 1'b1;
    wr_i = 1'b0;
    data_i = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_edges();
    test_random_frames();
    test_clear(1'b0);
    test_clear(1'b1);
    test_timeout();
    test_level_hold();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
